multi_channel_clock_divider: RTL and testbench
==============================================

# multi_channel_clock_divider

Runtime-programmable, N-channel clock divider. Each channel generates a divided clock-like output with near-50 % duty from the single system clock, plus single-cycle rise/fall strobes for logic that must stay in the `clk` domain. Divisor changes take effect only at period boundaries, so outputs never glitch. A common sync pulse phase-aligns all running channels. The block sits beside the fixed-ratio divider and feeds peripheral interfaces (SPI/I2C/UART bit clocks, LED scan) that need divisors chosen at run time.

## Interface
- `N_CHANNELS`, default 4: number of independent channels (≥1).
- `DIV_WIDTH`, default 16: width of each divisor field (≥2).
- `IDLE_STATE`, default 0: level of `divided_clk_out[i]` while channel i is stopped or in reset.
- `STOP_MODE`, default 0: 0 = stop immediately on enable deassert; 1 = finish the current period, then stop.
- `clk`, input, 1: sole clock, all logic on rising edge.
- `rst`, input, 1: asynchronous, active-high reset. This is already decided.
- `enable`, input, N_CHANNELS: per-channel run request, level-sensitive.
- `sync`, input, 1: single-cycle pulse that restarts every running channel at phase 0.
- `divisor`, input, N_CHANNELS*DIV_WIDTH: channel i occupies bits `[i*DIV_WIDTH +: DIV_WIDTH]`. The value is the period in `clk` cycles.
- `divided_clk_out`, output, N_CHANNELS: registered divided output.
- `rise_tick`, output, N_CHANNELS: 1-cycle strobe, coincident with the cycle in which `divided_clk_out[i]` goes high.
- `fall_tick`, output, N_CHANNELS: 1-cycle strobe, coincident with the cycle in which `divided_clk_out[i]` goes low.
- `busy`, output, N_CHANNELS: channel is in RUN or DRAIN.

## Operation
- Per-channel FSM with three states:
  - IDLE: `cnt`=0, output=`IDLE_STATE`, ticks=0.
  - RUN.
  - DRAIN: entered only when `STOP_MODE`=1.
- Divisor latch: `P` = divisor sampled at start and at each period boundary. Values 0 or 1 are clamped to 2. `H` = ceil(P/2) = high-phase length.
- Counter `cnt` is DIV_WIDTH bits and counts 0..P-1.
- Registered output in RUN/DRAIN: output = (cnt < H).
- IDLE→RUN, when `enable[i]`=1: cnt←0, P←clamp(divisor), out←1, `rise_tick`←1.
- RUN, when cnt≠P-1: cnt←cnt+1, out←(cnt+1<H). `fall_tick`←1 in the cycle out goes 1→0.
- RUN, when cnt=P-1 and enable=1 (boundary): cnt←0, P reloads, out←1, `rise_tick`←1.
- RUN, when enable=0:
  - `STOP_MODE`=0: go to IDLE next edge, out←`IDLE_STATE`, no ticks.
  - `STOP_MODE`=1: go to DRAIN and keep counting. At cnt=P-1, go to IDLE with out←`IDLE_STATE`.
- DRAIN with enable=1 again: return to RUN and continue the current period without a restart.
- `sync`=1: every channel in RUN or DRAIN takes the boundary action (cnt←0, P reload, out←1, `rise_tick`←1). IDLE channels ignore `sync`.
- Simultaneous events:
  - `sync` coinciding with a natural boundary produces one boundary action and one `rise_tick`.
  - `sync` with enable=0 in RUN and `STOP_MODE`=0: stop wins.
- When IDLE→RUN and out stays high across a boundary (P=2 is the shortest case, it still toggles), `rise_tick` fires only on an actual 0→1 transition or on a start from `IDLE_STATE`=0. With `IDLE_STATE`=1, start asserts no `rise_tick`.
- Divisor changes mid-period are ignored until the next boundary or sync.

## Timing
- Reset, asynchronous: all FSMs to IDLE, cnt=0, `divided_clk_out`=`{N{IDLE_STATE}}`, `rise_tick`=`fall_tick`=`busy`=0.
- Latency: `enable` sampled high at edge k gives output high after edge k and `busy`=1 after edge k.
- Steady-state period is P cycles, with output high for H cycles and low for P-H cycles. Odd P is high one cycle longer.
- Channels are fully independent apart from the shared `sync`.
- Deassert with `STOP_MODE`=0 gives output=`IDLE_STATE` after the next edge.
- Reset mid-period takes effect immediately. The following enable restarts from phase 0 with a fresh divisor.

## Structure
- Shared package `clock_divider_pkg`:
  - FSM state typedef (IDLE/RUN/DRAIN).
  - Divisor clamp constant `MIN_DIVISOR`=2.
  - Function `high_len(P)`.
- Sub-module `clock_divider_channel`, one per channel via generate. It holds the FSM, counter, divisor latch and tick logic.
- The top level only slices buses and fans out `sync`.

## Test plan
- N=1, divisor=4, `IDLE_STATE`=0, enable held → out 1,1,0,0 repeating; `rise_tick` every 4 cycles at cnt=0; `fall_tick` at cnt=2.
- divisor=5, then 0 → 5: out 1,1,1,0,0. With divisor=0: clamped P=2, out 1,0 toggling, both ticks alternate every cycle.
- divisor changed 4→6 at cnt=1 → the current period completes with 4 cycles; the next period has 6 cycles (3 high, 3 low), with no short pulse.
- `STOP_MODE`=0 vs 1, enable dropped at cnt=1 with P=8:
  - mode 0 → out=`IDLE_STATE` next cycle.
  - mode 1 → stays busy until cnt=7, then idle, total 7 more cycles.
- Channels 0/1 with divisors 6 and 9, `sync` pulse → both show `rise_tick` in the same cycle, with cnt=0 after the edge. An IDLE channel 2 stays at `IDLE_STATE`.
- `rst` asserted mid-high-phase → all outputs reach reset values with no clock edge. After release, enable restarts at phase 0.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared types, constants and helpers for the clock divider
package clock_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } div_state_t;

    localparam int MIN_DIVISOR = 2;

    // High-phase length: odd periods get the extra cycle in the high phase.
    function automatic logic [31:0] high_len(input logic [31:0] p);
        return (p >> 1) + {31'd0, p[0]};
    endfunction

endpackage

// File: rtl/multi_channel_clock_divider_if.sv
// rtl/multi_channel_clock_divider_if.sv - control/status bundle of the multi-channel divider
interface multi_channel_clock_divider_if #(
    parameter int N_CHANNELS = 4,
    parameter int DIV_WIDTH  = 16
);
    logic [N_CHANNELS-1:0]           enable;
    logic                            sync;
    logic [N_CHANNELS*DIV_WIDTH-1:0] divisor;
    logic [N_CHANNELS-1:0]           divided_clk_out;
    logic [N_CHANNELS-1:0]           rise_tick;
    logic [N_CHANNELS-1:0]           fall_tick;
    logic [N_CHANNELS-1:0]           busy;

    modport master (
        output enable, sync, divisor,
        input  divided_clk_out, rise_tick, fall_tick, busy
    );

    modport slave (
        input  enable, sync, divisor,
        output divided_clk_out, rise_tick, fall_tick, busy
    );
endinterface

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel: FSM, period counter, divisor latch, ticks
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter bit IDLE_STATE = 1'b0,
    parameter bit STOP_MODE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_sync,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    output logic                 o_clk,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_busy
);

    div_state_t           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_p;
    logic                 r_out;
    logic                 r_rise;
    logic                 r_fall;

    logic [DIV_WIDTH-1:0] w_p_new;
    logic [DIV_WIDTH-1:0] w_h;
    logic [DIV_WIDTH-1:0] w_cnt_inc;
    logic                 w_last;
    logic                 w_next_high;

    assign w_p_new     = (i_divisor < DIV_WIDTH'(MIN_DIVISOR)) ? DIV_WIDTH'(MIN_DIVISOR) : i_divisor;
    assign w_h         = DIV_WIDTH'(high_len(32'(r_p)));
    assign w_cnt_inc   = r_cnt + DIV_WIDTH'(1);
    assign w_last      = (r_cnt == r_p - DIV_WIDTH'(1));
    assign w_next_high = (w_cnt_inc < w_h);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_p     <= DIV_WIDTH'(MIN_DIVISOR);
            r_out   <= IDLE_STATE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (i_enable) begin
                        r_state <= ST_RUN;
                        r_p     <= w_p_new;
                        r_out   <= 1'b1;
                        r_rise  <= (IDLE_STATE == 1'b0);
                    end else begin
                        r_out <= IDLE_STATE;
                    end
                end
                default: begin
                    // Immediate stop outranks a coincident sync.
                    if (!i_enable && !STOP_MODE) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_out   <= IDLE_STATE;
                    end else if (i_sync || (w_last && i_enable)) begin
                        r_state <= i_enable ? ST_RUN : ST_DRAIN;
                        r_cnt   <= '0;
                        r_p     <= w_p_new;
                        r_out   <= 1'b1;
                        r_rise  <= !r_out;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_out   <= IDLE_STATE;
                    end else begin
                        r_state <= i_enable ? ST_RUN : ST_DRAIN;
                        r_cnt   <= w_cnt_inc;
                        r_out   <= w_next_high;
                        r_fall  <= r_out && !w_next_high;
                    end
                end
            endcase
        end
    end

    assign o_clk  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/multi_channel_clock_divider.sv
// rtl/multi_channel_clock_divider.sv - N independent runtime-programmable clock divider channels
module multi_channel_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int DIV_WIDTH  = 16,
    parameter bit IDLE_STATE = 1'b0,
    parameter bit STOP_MODE  = 1'b0
) (
    input logic                          clk,
    input logic                          rst,
    multi_channel_clock_divider_if.slave bus
);

    logic [N_CHANNELS-1:0] w_out;
    logic [N_CHANNELS-1:0] w_rise;
    logic [N_CHANNELS-1:0] w_fall;
    logic [N_CHANNELS-1:0] w_busy;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        clock_divider_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .IDLE_STATE (IDLE_STATE),
            .STOP_MODE  (STOP_MODE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_enable  (bus.enable[i]),
            .i_sync    (bus.sync),
            .i_divisor (bus.divisor[i*DIV_WIDTH +: DIV_WIDTH]),
            .o_clk     (w_out[i]),
            .o_rise    (w_rise[i]),
            .o_fall    (w_fall[i]),
            .o_busy    (w_busy[i])
        );
    end

    assign bus.divided_clk_out = w_out;
    assign bus.rise_tick       = w_rise;
    assign bus.fall_tick       = w_fall;
    assign bus.busy            = w_busy;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb/tb_multi_channel_clock_divider.sv - scoreboard bench for the multi-channel clock divider
module tb_multi_channel_clock_divider;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_channel_clock_divider_if #(.N_CHANNELS(4), .DIV_WIDTH(DW)) bus_a ();
    multi_channel_clock_divider_if #(.N_CHANNELS(1), .DIV_WIDTH(DW)) bus_b ();

    multi_channel_clock_divider #(
        .N_CHANNELS(4), .DIV_WIDTH(DW), .IDLE_STATE(1'b0), .STOP_MODE(1'b0)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    multi_channel_clock_divider #(
        .N_CHANNELS(1), .DIV_WIDTH(DW), .IDLE_STATE(1'b1), .STOP_MODE(1'b1)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // exp = {out, rise_tick, fall_tick, busy}
    typedef struct {
        int         dut;
        int         ch;
        logic [3:0] exp;
    } exp_t;

    typedef struct {
        int div;
        int p;
        int cycles;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;
    string cur_test = "init";

    function automatic logic [3:0] actual(int dut, int ch);
        if (dut == 0)
            return {bus_a.divided_clk_out[ch], bus_a.rise_tick[ch], bus_a.fall_tick[ch], bus_a.busy[ch]};
        return {bus_b.divided_clk_out[0], bus_b.rise_tick[0], bus_b.fall_tick[0], bus_b.busy[0]};
    endfunction

    // Ideal running waveform at phase cnt of a period p.
    function automatic logic [3:0] steady(int p, int cnt);
        int h;
        h = (p + 1) / 2;
        return {(cnt < h), (cnt == 0), (cnt == h), 1'b1};
    endfunction

    task automatic push(int dut, int ch, logic [3:0] e);
        exp_t x;
        x.dut = dut;
        x.ch  = ch;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_now();
        exp_t       x;
        logic [3:0] a;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            a = actual(x.dut, x.ch);
            checks++;
            if (a !== x.exp) begin
                errors++;
                $display("FAIL %s dut%0d ch%0d {out,rise,fall,busy} got=%b expected=%b",
                         cur_test, x.dut, x.ch, a, x.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic push_reset_state();
        for (int c = 0; c < 4; c++) push(0, c, 4'b0000);
        push(1, 0, 4'b1000);
    endtask

    task automatic do_reset();
        bus_a.enable = '0;
        bus_a.sync   = 1'b0;
        bus_b.enable = '0;
        bus_b.sync   = 1'b0;
        rst = 1'b1;
        #2;
        push_reset_state();
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_div_a(int ch, int d);
        bus_a.divisor[ch*DW +: DW] = DW'(d);
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.enable  = '0;
        bus_a.sync    = 1'b0;
        bus_a.divisor = '0;
        bus_b.enable  = '0;
        bus_b.sync    = 1'b0;
        bus_b.divisor = '0;

        vecs[0] = '{div: 4, p: 4, cycles: 12};
        vecs[1] = '{div: 5, p: 5, cycles: 15};
        vecs[2] = '{div: 0, p: 2, cycles: 6};
        vecs[3] = '{div: 1, p: 2, cycles: 6};
        vecs[4] = '{div: 2, p: 2, cycles: 4};
        vecs[5] = '{div: 3, p: 3, cycles: 9};
        vecs[6] = '{div: 7, p: 7, cycles: 14};

        cur_test = "reset";
        #3;
        push_reset_state();
        check_now();

        cur_test = "table";
        for (int v = 0; v < 7; v++) begin
            do_reset();
            set_div_a(0, vecs[v].div);
            bus_a.enable[0] = 1'b1;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                push(0, 0, steady(vecs[v].p, c % vecs[v].p));
                push(0, 1, 4'b0000);
                step();
            end
            bus_a.enable[0] = 1'b0;
            push(0, 0, 4'b0000);
            step();
        end

        cur_test = "div_change";
        do_reset();
        set_div_a(0, 4);
        bus_a.enable[0] = 1'b1;
        push(0, 0, steady(4, 0)); step();
        push(0, 0, steady(4, 1)); step();
        set_div_a(0, 6);
        for (int c = 2; c < 4; c++) begin push(0, 0, steady(4, c)); step(); end
        for (int c = 0; c < 12; c++) begin push(0, 0, steady(6, c % 6)); step(); end

        cur_test = "stop_mode0";
        do_reset();
        set_div_a(0, 8);
        bus_a.enable[0] = 1'b1;
        push(0, 0, steady(8, 0)); step();
        push(0, 0, steady(8, 1)); step();
        bus_a.enable[0] = 1'b0;
        push(0, 0, 4'b0000); step();
        push(0, 0, 4'b0000); step();

        cur_test = "stop_mode1";
        do_reset();
        bus_b.divisor = DW'(8);
        bus_b.enable  = 1'b1;
        push(1, 0, 4'b1001); step();
        push(1, 0, steady(8, 1)); step();
        bus_b.enable = 1'b0;
        for (int c = 2; c < 8; c++) begin push(1, 0, steady(8, c)); step(); end
        push(1, 0, 4'b1000); step();
        push(1, 0, 4'b1000); step();

        cur_test = "drain_resume";
        bus_b.enable = 1'b1;
        push(1, 0, 4'b1001); step();
        push(1, 0, steady(8, 1)); step();
        bus_b.enable = 1'b0;
        push(1, 0, steady(8, 2)); step();
        push(1, 0, steady(8, 3)); step();
        bus_b.enable = 1'b1;
        for (int c = 4; c < 8; c++) begin push(1, 0, steady(8, c)); step(); end
        push(1, 0, steady(8, 0)); step();

        cur_test = "sync_align";
        do_reset();
        set_div_a(0, 6);
        set_div_a(1, 9);
        set_div_a(2, 5);
        bus_a.enable = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            push(0, 0, steady(6, c)); push(0, 1, steady(9, c)); push(0, 2, 4'b0000);
            step();
        end
        bus_a.sync = 1'b1;
        push(0, 0, steady(6, 0)); push(0, 1, steady(9, 0)); push(0, 2, 4'b0000);
        step();
        bus_a.sync = 1'b0;
        for (int c = 1; c < 9; c++) begin
            push(0, 0, steady(6, c % 6)); push(0, 1, steady(9, c)); push(0, 2, 4'b0000);
            step();
        end

        cur_test = "sync_on_boundary";
        do_reset();
        set_div_a(0, 4);
        bus_a.enable[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin push(0, 0, steady(4, c)); step(); end
        bus_a.sync = 1'b1;
        push(0, 0, steady(4, 0)); step();
        bus_a.sync = 1'b0;
        for (int c = 1; c < 4; c++) begin push(0, 0, steady(4, c)); step(); end
        push(0, 0, steady(4, 0)); step();

        cur_test = "sync_vs_stop";
        bus_a.sync      = 1'b1;
        bus_a.enable[0] = 1'b0;
        push(0, 0, 4'b0000); step();
        bus_a.sync = 1'b0;
        push(0, 0, 4'b0000); step();

        cur_test = "async_reset";
        do_reset();
        set_div_a(0, 6);
        bus_a.enable[0] = 1'b1;
        push(0, 0, steady(6, 0)); step();
        push(0, 0, steady(6, 1)); step();
        #2;
        rst = 1'b1;
        #1;
        push_reset_state();
        check_now();
        set_div_a(0, 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin push(0, 0, steady(4, c % 4)); step(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
